// File: rtl/tp_pkg.sv
// Shared encodings, error codes and FSM state type for the transpose job sequencer.
package tp_pkg;

    localparam logic [6:0] OPC_RTYPE = 7'h33;
    localparam logic [6:0] F7_TP     = 7'h02;

    localparam logic [2:0] F3_AWR   = 3'd0;
    localparam logic [2:0] F3_START = 3'd1;
    localparam logic [2:0] F3_STAT  = 3'd2;
    localparam logic [2:0] F3_BRD   = 3'd3;

    localparam logic [4:0] RD_NONE = 5'd0;
    localparam logic [4:0] RD_STAT = 5'd1;
    localparam logic [4:0] RD_BRD  = 5'd2;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_DIMS    = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_e;

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_LD_RD, S_LD_WAIT, S_LD_ISS, S_START, S_POLL_ISS,
        S_POLL_WAIT, S_GAP, S_POST, S_RD_ISS, S_RD_WAIT, S_WB, S_FIN
    } state_e;

    // Accelerator R-type word; rs1/rs2 register fields are unused and kept zero.
    function automatic logic [31:0] enc_rtype(input logic [2:0] funct3, input logic [4:0] rd);
        return {F7_TP, 5'd0, 5'd0, funct3, rd, OPC_RTYPE};
    endfunction

endpackage

// File: rtl/tp_job_sequencer_if.sv
// Job, memory and accelerator-instruction signals of the sequencer, seen from both sides.
interface tp_job_sequencer_if #(
    parameter int MEM_AW = 32,
    parameter int DATA_W = 32
);
    logic              job_valid;
    logic              job_ready;
    logic [MEM_AW-1:0] job_src_base;
    logic [MEM_AW-1:0] job_dst_base;
    logic [15:0]       job_rows;
    logic [15:0]       job_cols;
    logic              busy;
    logic              done;
    logic [1:0]        err;

    logic              mem_rd_req;
    logic [MEM_AW-1:0] mem_rd_addr;
    logic              mem_rd_rvalid;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_wr_en;
    logic [MEM_AW-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;

    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [31:0]       rs1_val;
    logic [31:0]       rs2_val;
    logic [4:0]        rd_addr;
    logic              rd_we;
    logic [4:0]        rd_waddr;
    logic [31:0]       rd_wdata;

    modport master (
        input  job_valid, job_src_base, job_dst_base, job_rows, job_cols,
               mem_rd_rvalid, mem_rd_data, instr_ready, rd_we, rd_waddr, rd_wdata,
        output job_ready, busy, done, err, mem_rd_req, mem_rd_addr,
               mem_wr_en, mem_wr_addr, mem_wr_data,
               instr_valid, instr, rs1_val, rs2_val, rd_addr
    );

    modport slave (
        output job_valid, job_src_base, job_dst_base, job_rows, job_cols,
               mem_rd_rvalid, mem_rd_data, instr_ready, rd_we, rd_waddr, rd_wdata,
        input  job_ready, busy, done, err, mem_rd_req, mem_rd_addr,
               mem_wr_en, mem_wr_addr, mem_wr_data,
               instr_valid, instr, rs1_val, rs2_val, rd_addr
    );

endinterface

// File: rtl/tp_rc_walker.sv
// Two-level index counter: inner wraps to 0 and bumps outer; last flags the final (outer, inner) pair.
module tp_rc_walker (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        step_i,
    input  logic [15:0] outer_lim_i,
    input  logic [15:0] inner_lim_i,
    output logic [15:0] outer_o,
    output logic [15:0] inner_o,
    output logic        last_o
);
    logic [15:0] outer_q, outer_d;
    logic [15:0] inner_q, inner_d;
    logic        inner_wrap;

    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        inner_wrap = (inner_q == inner_lim_i - 16'd1);
        outer_d    = outer_q;
        inner_d    = inner_q;
        if (clear_i) begin
            outer_d = '0;
            inner_d = '0;
        end else if (step_i) begin
            if (inner_wrap) begin
                inner_d = '0;
                outer_d = outer_q + 16'd1;
            end else begin
                inner_d = inner_q + 16'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outer_q <= '0;
            inner_q <= '0;
        end else begin
            outer_q <= outer_d;
            inner_q <= inner_d;
        end
    end

    assign outer_o = outer_q;
    assign inner_o = inner_q;
    assign last_o  = inner_wrap && (outer_q == outer_lim_i - 16'd1);

endmodule

// File: rtl/tp_job_sequencer.sv
// Runs one transpose job: load A through AWR, START, poll STAT, read B through BRD and store it to dst.
module tp_job_sequencer
    import tp_pkg::*;
#(
    parameter int M         = 8,
    parameter int N         = 8,
    parameter int DATA_W    = 32,
    parameter int MEM_AW    = 32,
    parameter int POLL_GAP  = 4,
    parameter int MAX_POLLS = 1024
) (
    input logic               clk_i,
    input logic               rst_i,
    tp_job_sequencer_if.master bus
);
    localparam int PW = $clog2(MAX_POLLS + 1);
    localparam int GW = $clog2(POLL_GAP + 1);

    state_e            state_q, state_d;
    logic [MEM_AW-1:0] src_q, src_d, dst_q, dst_d;
    logic [15:0]       rows_q, rows_d, cols_q, cols_d;
    logic [DATA_W-1:0] data_q, data_d;
    err_e              err_q, err_d;
    logic              done_q, done_d;
    logic [PW-1:0]     poll_q, poll_d;
    logic [GW-1:0]     gap_q, gap_d;

    logic              walk_clear, walk_step, walk_last, rd_phase, dims_bad;
    logic [15:0]       outer, inner, outer_lim, inner_lim;

    // Load walks rows x cols of A; readback walks cols x rows so B comes out row-major.
    assign rd_phase  = state_q inside {S_POST, S_RD_ISS, S_RD_WAIT, S_WB};
    assign outer_lim = rd_phase ? cols_q : rows_q;
    assign inner_lim = rd_phase ? rows_q : cols_q;
    assign dims_bad  = (rows_q == 16'd0) || (cols_q == 16'd0) ||
                       (rows_q > 16'(M)) || (cols_q > 16'(N));

    tp_rc_walker u_walker (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (walk_clear),
        .step_i      (walk_step),
        .outer_lim_i (outer_lim),
        .inner_lim_i (inner_lim),
        .outer_o     (outer),
        .inner_o     (inner),
        .last_o      (walk_last)
    );

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        data_d     = data_q;
        err_d      = err_q;
        done_d     = 1'b0;
        poll_d     = poll_q;
        gap_d      = gap_q;
        walk_clear = 1'b0;
        walk_step  = 1'b0;
        unique case (state_q)
            S_IDLE: if (bus.job_valid) begin
                src_d   = bus.job_src_base;
                dst_d   = bus.job_dst_base;
                rows_d  = bus.job_rows;
                cols_d  = bus.job_cols;
                err_d   = ERR_OK;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                walk_clear = 1'b1;
                if (dims_bad) begin
                    err_d   = ERR_DIMS;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LD_RD;
                end
            end
            S_LD_RD:   state_d = S_LD_WAIT;
            S_LD_WAIT: if (bus.mem_rd_rvalid) begin
                data_d  = bus.mem_rd_data;
                state_d = S_LD_ISS;
            end
            S_LD_ISS: if (bus.instr_ready) begin
                if (walk_last) state_d = S_START;
                else begin
                    walk_step = 1'b1;
                    state_d   = S_LD_RD;
                end
            end
            S_START: if (bus.instr_ready) begin
                poll_d  = '0;
                state_d = S_POLL_ISS;
            end
            S_POLL_ISS: if (bus.instr_ready) begin
                poll_d  = poll_q + PW'(1);
                state_d = S_POLL_WAIT;
            end
            S_POLL_WAIT: if (bus.rd_we && bus.rd_waddr == RD_STAT) begin
                if (bus.rd_wdata[0]) state_d = S_POST;
                else if (poll_q == PW'(MAX_POLLS)) begin
                    err_d   = ERR_TIMEOUT;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(POLL_GAP - 1)) state_d = S_POLL_ISS;
                else gap_d = gap_q + GW'(1);
            end
            S_POST: begin
                walk_clear = 1'b1;
                state_d    = S_RD_ISS;
            end
            S_RD_ISS:  if (bus.instr_ready) state_d = S_RD_WAIT;
            S_RD_WAIT: if (bus.rd_we && bus.rd_waddr == RD_BRD) begin
                data_d  = DATA_W'(bus.rd_wdata);
                state_d = S_WB;
            end
            S_WB: begin
                if (walk_last) state_d = S_FIN;
                else begin
                    walk_step = 1'b1;
                    state_d   = S_RD_ISS;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: a synchronous reset clears every state flop, which aborts a job without a done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rows_q  <= '0;
            cols_q  <= '0;
            data_q  <= '0;
            err_q   <= ERR_OK;
            done_q  <= 1'b0;
            poll_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            data_q  <= data_d;
            err_q   <= err_d;
            done_q  <= done_d;
            poll_q  <= poll_d;
            gap_q   <= gap_d;
        end
    end

    // Instruction payload is built only from flops that hold still until the handshake completes.
    logic       iss_valid;
    logic [2:0] iss_f3;
    logic [4:0] iss_rd;

    always_comb begin
        iss_valid = 1'b1;
        iss_f3    = F3_AWR;
        iss_rd    = RD_NONE;
        unique case (state_q)
            S_LD_ISS:   iss_f3 = F3_AWR;
            S_START:    iss_f3 = F3_START;
            S_POLL_ISS: begin
                iss_f3 = F3_STAT;
                iss_rd = RD_STAT;
            end
            S_RD_ISS: begin
                iss_f3 = F3_BRD;
                iss_rd = RD_BRD;
            end
            default:    iss_valid = 1'b0;
        endcase
    end

    assign bus.instr_valid = iss_valid;
    assign bus.instr       = iss_valid ? enc_rtype(iss_f3, iss_rd) : '0;
    assign bus.rs1_val     = (state_q inside {S_LD_ISS, S_RD_ISS}) ? {outer, inner} : '0;
    assign bus.rs2_val     = (state_q == S_LD_ISS) ? 32'(data_q) : '0;
    assign bus.rd_addr     = iss_rd;

    assign bus.job_ready   = (state_q == S_IDLE);
    assign bus.busy        = !(state_q inside {S_IDLE, S_FIN});
    assign bus.done        = done_q || (state_q == S_FIN);
    assign bus.err         = err_q;

    assign bus.mem_rd_req  = (state_q == S_LD_RD);
    assign bus.mem_rd_addr = bus.mem_rd_req
                           ? src_q + MEM_AW'(outer) * MEM_AW'(cols_q) + MEM_AW'(inner) : '0;
    assign bus.mem_wr_en   = (state_q == S_WB);
    assign bus.mem_wr_addr = bus.mem_wr_en
                           ? dst_q + MEM_AW'(outer) * MEM_AW'(rows_q) + MEM_AW'(inner) : '0;
    assign bus.mem_wr_data = bus.mem_wr_en ? data_q : '0;

endmodule

// File: tb/tb_tp_job_sequencer.sv
// Scoreboarded bench: word memory and transpose-accelerator stub driven on the falling edge.
module tb_tp_job_sequencer;

    localparam int MAX_POLLS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tp_job_sequencer_if #(.MEM_AW(32), .DATA_W(32)) bus ();

    tp_job_sequencer #(
        .M(8), .N(8), .DATA_W(32), .MEM_AW(32), .POLL_GAP(4), .MAX_POLLS(MAX_POLLS)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [logic [31:0]];
    wr_t         exp_q [$];
    logic [31:0] acc_a [8][8];

    bit stall_mode = 1'b0;
    bit never_done = 1'b0;
    int job_rows, job_cols;
    int awr_cnt, awr_oob, brd_cnt, stat_cnt, iv_cnt, dn_cnt, wr_cnt, rdreq_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gen(input int r, input int c);
        return 32'h3f80_0000 + 32'(r << 8) + 32'(c);
    endfunction

    function automatic logic [31:0] exp_instr(input logic [2:0] f3, input logic [4:0] rd);
        return {7'h02, 10'd0, f3, rd, 7'h33};
    endfunction

    // Memory, accelerator stub and write scoreboard, all evaluated on the falling edge.
    initial begin
        bit          rd_pending, wb_pending, held;
        int          rd_cnt, wb_cnt, r, c;
        logic [31:0] rd_addr_l, wb_data, h_instr, h_rs1, h_rs2;
        logic [4:0]  wb_waddr, h_rd, e_rd;
        logic [2:0]  f3;
        wr_t         e;
        rd_pending = 1'b0; wb_pending = 1'b0; held = 1'b0;
        bus.instr_ready = 1'b0; bus.mem_rd_rvalid = 1'b0; bus.mem_rd_data = '0;
        bus.rd_we = 1'b0; bus.rd_waddr = '0; bus.rd_wdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_rd_rvalid = 1'b0;
            bus.rd_we         = 1'b0;
            bus.rd_waddr      = '0;
            if (bus.done) dn_cnt++;
            if (bus.mem_rd_req) rdreq_cnt++;
            if (rst) begin
                rd_pending = 1'b0; wb_pending = 1'b0; held = 1'b0;
                bus.instr_ready = 1'b0;
                continue;
            end
            if (rd_pending) begin
                if (rd_cnt <= 1) begin
                    bus.mem_rd_rvalid = 1'b1;
                    bus.mem_rd_data   = mem.exists(rd_addr_l) ? mem[rd_addr_l] : 32'hDEAD_BEEF;
                    rd_pending        = 1'b0;
                end else rd_cnt--;
            end
            if (bus.mem_rd_req) begin
                rd_pending = 1'b1;
                rd_addr_l  = bus.mem_rd_addr;
                rd_cnt     = stall_mode ? int'($urandom_range(5, 1)) : 1;
            end
            if (bus.mem_wr_en) begin
                wr_cnt++;
                check("wr_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", bus.mem_wr_addr, e.addr);
                    check("wr_data", bus.mem_wr_data, e.data);
                end
                mem[bus.mem_wr_addr] = bus.mem_wr_data;
            end
            if (held) begin
                check("stall_valid", bus.instr_valid, 1);
                check("stall_instr", bus.instr, h_instr);
                check("stall_rs1", bus.rs1_val, h_rs1);
                check("stall_rs2", bus.rs2_val, h_rs2);
                check("stall_rd", bus.rd_addr, h_rd);
            end
            held = 1'b0;
            if (wb_pending) begin
                if (wb_cnt <= 1) begin
                    bus.rd_we = 1'b1; bus.rd_waddr = wb_waddr; bus.rd_wdata = wb_data;
                    wb_pending = 1'b0;
                end else begin
                    wb_cnt--;
                    if (stall_mode) begin
                        bus.rd_we = 1'b1; bus.rd_waddr = 5'd7; bus.rd_wdata = 32'hFFFF_FFFF;
                    end
                end
            end
            bus.instr_ready = stall_mode ? ($urandom_range(3, 0) != 0) : 1'b1;
            if (bus.instr_valid) begin
                iv_cnt++;
                if (!bus.instr_ready) begin
                    held = 1'b1;
                    h_instr = bus.instr; h_rs1 = bus.rs1_val; h_rs2 = bus.rs2_val; h_rd = bus.rd_addr;
                end else begin
                    f3   = bus.instr[14:12];
                    e_rd = (f3 == 3'd2) ? 5'd1 : (f3 == 3'd3) ? 5'd2 : 5'd0;
                    check("instr_word", bus.instr, exp_instr(f3, e_rd));
                    check("instr_rd", bus.rd_addr, e_rd);
                    r = int'(bus.rs1_val[31:16]);
                    c = int'(bus.rs1_val[15:0]);
                    case (f3)
                        3'd0: begin
                            awr_cnt++;
                            if (r < job_rows && c < job_cols) acc_a[r][c] = bus.rs2_val;
                            else awr_oob++;
                        end
                        3'd2: begin
                            stat_cnt++;
                            wb_pending = 1'b1; wb_waddr = 5'd1;
                            wb_cnt  = stall_mode ? int'($urandom_range(4, 1)) : 1;
                            wb_data = (!never_done && stat_cnt >= 2) ? 32'h1 : 32'h2;
                        end
                        3'd3: begin
                            brd_cnt++;
                            wb_pending = 1'b1; wb_waddr = 5'd2;
                            wb_cnt  = stall_mode ? int'($urandom_range(4, 1)) : 1;
                            wb_data = (r < 8 && c < 8) ? acc_a[c][r] : 32'hBAD0_0000;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic start_job(input logic [31:0] src, input logic [31:0] dst,
                             input int rows, input int cols, input bit expect_wb);
        wr_t e;
        job_rows = rows; job_cols = cols;
        awr_cnt = 0; awr_oob = 0; brd_cnt = 0; stat_cnt = 0; iv_cnt = 0; wr_cnt = 0; rdreq_cnt = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) acc_a[i][j] = 32'hCAFE_0000;
        if (rows >= 1 && rows <= 8 && cols >= 1 && cols <= 8) begin
            for (int r = 0; r < rows; r++)
                for (int c = 0; c < cols; c++) mem[src + 32'(r * cols + c)] = gen(r, c);
            if (expect_wb)
                for (int rp = 0; rp < cols; rp++)
                    for (int cp = 0; cp < rows; cp++) begin
                        e.addr = dst + 32'(rp * rows + cp);
                        e.data = gen(cp, rp);
                        exp_q.push_back(e);
                    end
        end
        for (int i = 0; i < 50 && !bus.job_ready; i++) @(negedge clk);
        check("job_ready_idle", bus.job_ready, 1);
        dn_cnt = 0;
        bus.job_valid = 1'b1; bus.job_src_base = src; bus.job_dst_base = dst;
        bus.job_rows = 16'(rows); bus.job_cols = 16'(cols);
        @(negedge clk);
        bus.job_valid = 1'b0; bus.job_src_base = '1; bus.job_dst_base = '1;
        bus.job_rows = '0; bus.job_cols = '0;
        check("busy_after_accept", bus.busy, 1);
    endtask

    task automatic finish_job(input logic [1:0] exp_err, input int max_cyc, output int cyc);
        cyc = 1;
        while (!bus.done && cyc < max_cyc) begin
            if (cyc == 3 && exp_err == 2'd0) check("ready_while_busy", bus.job_ready, 0);
            @(negedge clk);
            cyc++;
        end
        check("done_seen", bus.done, 1);
        check("err_at_done", bus.err, exp_err);
        check("busy_at_done", bus.busy, 0);
        repeat (3) @(negedge clk);
        check("done_pulses", dn_cnt, 1);
        check("err_sticky", bus.err, exp_err);
        check("wr_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_job_ready"}, bus.job_ready, 1);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_mem_rd"}, {bus.mem_rd_req, bus.mem_rd_addr}, 0);
        check({tag, "_mem_wr"}, {bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data}, 0);
        check({tag, "_instr"}, {bus.instr_valid, bus.instr, bus.rd_addr}, 0);
        check({tag, "_rs"}, {bus.rs1_val, bus.rs2_val}, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        bus.job_valid = 1'b0; bus.job_src_base = '0; bus.job_dst_base = '0;
        bus.job_rows = '0; bus.job_cols = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;

        start_job(32'h1000, 32'h2000, 8, 8, 1'b1);
        finish_job(2'd0, 5000, cyc);
        check("t8x8_awr", awr_cnt, 64);
        check("t8x8_brd", brd_cnt, 64);

        start_job(32'h100, 32'h300, 3, 5, 1'b1);
        finish_job(2'd0, 3000, cyc);
        check("t3x5_awr", awr_cnt, 15);
        check("t3x5_awr_outside", awr_oob, 0);
        check("t3x5_wr", wr_cnt, 15);

        start_job(32'h0, 32'h0, 0, 4, 1'b1);
        finish_job(2'd1, 10, cyc);
        check("rows0_fast", 64'(cyc <= 3), 1);
        check("rows0_no_instr", iv_cnt, 0);

        start_job(32'h0, 32'h0, 9, 4, 1'b1);
        finish_job(2'd1, 10, cyc);
        check("rows9_fast", 64'(cyc <= 3), 1);
        check("rows9_no_instr", iv_cnt, 0);

        stall_mode = 1'b1;
        start_job(32'h4000, 32'hFFFF_FFF0, 8, 8, 1'b1);
        finish_job(2'd0, 20000, cyc);
        check("stall_awr", awr_cnt, 64);
        stall_mode = 1'b0;

        never_done = 1'b1;
        start_job(32'h500, 32'h600, 2, 2, 1'b0);
        finish_job(2'd2, 2000, cyc);
        check("timeout_stats", stat_cnt, MAX_POLLS);
        check("timeout_no_wr", wr_cnt, 0);
        never_done = 1'b0;

        start_job(32'h1000, 32'h2000, 8, 8, 1'b1);
        for (int i = 0; i < 2000 && awr_cnt < 10; i++) @(negedge clk);
        check("rst_at_elem10", awr_cnt, 10);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        iv_cnt = 0; rdreq_cnt = 0; dn_cnt = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("midrst_no_instr", iv_cnt, 0);
        check("midrst_no_rdreq", rdreq_cnt, 0);
        check("midrst_no_done", dn_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        start_job(32'h700, 32'h800, 2, 2, 1'b1);
        finish_job(2'd0, 1000, cyc);
        check("t2x2_awr", awr_cnt, 4);
        check("t2x2_wr", wr_cnt, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
